// File: rtl/count_frame_tx.sv
// Count response framer: latches a finished photon count and sends it as 16-bit words over a valid/ready handshake.
// Optional macro FRAME_CHECKSUM_EN appends a 16-bit sum word, giving 4-word frames instead of 3.
module count_frame_tx #(
    parameter int          COUNT_W = 32,
    parameter logic [7:0]  HEADER  = 8'hA5
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [COUNT_W-1:0] COUNT_VALUE,
    input  logic               COUNT_DONE,
    input  logic               READ_REQ,
    output logic [15:0]        TX_DATA,
    output logic               TX_VALID,
    input  logic               TX_READY,
    output logic               BUSY,
    output logic               OVERRUN
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_HDR,
        S_CNT_HI,
        S_CNT_LO
`ifdef FRAME_CHECKSUM_EN
        , S_CSUM
`endif
    } state_t;

    state_t      state_q;
    logic [31:0] lat_q;
    logic [31:0] snap_q;
    logic        fresh_q;
    logic        fsnap_q;
    logic [5:0]  seq_q;
    logic        req_q;
    logic [15:0] tx_data_q;
    logic        tx_valid_q;
    logic        busy_q;
    logic        overrun_q;

    logic [31:0] count_ext_d;
    logic        req_rise_d;
    logic        xfer_d;
    logic [15:0] hdr_word_d;

    assign count_ext_d = 32'(COUNT_VALUE);
    assign req_rise_d  = READ_REQ & ~req_q;
    assign xfer_d      = tx_valid_q & TX_READY;
    assign hdr_word_d  = {HEADER, fsnap_q, 1'b0, seq_q};

`ifdef FRAME_CHECKSUM_EN
    function automatic logic [15:0] frame_sum(input logic [15:0] hdr, input logic [31:0] cnt);
        frame_sum = hdr + cnt[31:16] + cnt[15:0];
    endfunction
`endif

    // Capture, request edge detection and frame sequencing.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= S_IDLE;
            lat_q      <= 32'd0;
            snap_q     <= 32'd0;
            fresh_q    <= 1'b0;
            fsnap_q    <= 1'b0;
            seq_q      <= 6'd0;
            req_q      <= 1'b0;
            tx_data_q  <= 16'd0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            req_q <= READ_REQ;
            if (COUNT_DONE) begin
                lat_q   <= count_ext_d;
                fresh_q <= 1'b1;
                if (busy_q) begin
                    overrun_q <= 1'b1;
                end
            end
            case (state_q)
                S_IDLE: begin
                    if (req_rise_d) begin
                        // A count arriving in the start cycle wins over the older latch.
                        snap_q    <= COUNT_DONE ? count_ext_d : lat_q;
                        fsnap_q   <= fresh_q | COUNT_DONE;
                        fresh_q   <= 1'b0;
                        overrun_q <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= S_PREP;
                    end
                end
                S_PREP: begin
                    tx_data_q  <= hdr_word_d;
                    tx_valid_q <= 1'b1;
                    state_q    <= S_HDR;
                end
                S_HDR: begin
                    if (xfer_d) begin
                        tx_data_q <= snap_q[31:16];
                        state_q   <= S_CNT_HI;
                    end
                end
                S_CNT_HI: begin
                    if (xfer_d) begin
                        tx_data_q <= snap_q[15:0];
                        state_q   <= S_CNT_LO;
                    end
                end
                S_CNT_LO: begin
                    if (xfer_d) begin
`ifdef FRAME_CHECKSUM_EN
                        tx_data_q <= frame_sum(hdr_word_d, snap_q);
                        state_q   <= S_CSUM;
`else
                        tx_valid_q <= 1'b0;
                        busy_q     <= 1'b0;
                        seq_q      <= seq_q + 6'd1;
                        state_q    <= S_IDLE;
`endif
                    end
                end
`ifdef FRAME_CHECKSUM_EN
                S_CSUM: begin
                    if (xfer_d) begin
                        tx_valid_q <= 1'b0;
                        busy_q     <= 1'b0;
                        seq_q      <= seq_q + 6'd1;
                        state_q    <= S_IDLE;
                    end
                end
`endif
                default: begin
                    tx_valid_q <= 1'b0;
                    busy_q     <= 1'b0;
                    state_q    <= S_IDLE;
                end
            endcase
        end
    end

    assign TX_DATA  = tx_data_q;
    assign TX_VALID = tx_valid_q;
    assign BUSY     = busy_q;
    assign OVERRUN  = overrun_q;

endmodule

// File: tb/tb_count_frame_tx.sv
// Directed bench for count_frame_tx: frame contents, stall, overrun, same-cycle capture, SEQ wrap and mid-frame reset.
module tb_count_frame_tx;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [31:0] COUNT_VALUE = 32'd0;
    logic        COUNT_DONE = 1'b0;
    logic        READ_REQ = 1'b0;
    logic [15:0] TX_DATA;
    logic        TX_VALID;
    logic        TX_READY = 1'b1;
    logic        BUSY;
    logic        OVERRUN;

    int checks = 0;
    int errors = 0;

    count_frame_tx #(.COUNT_W(32), .HEADER(8'hA5)) dut (
        .CLK(CLK), .RST(RST), .COUNT_VALUE(COUNT_VALUE), .COUNT_DONE(COUNT_DONE),
        .READ_REQ(READ_REQ), .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_READY(TX_READY),
        .BUSY(BUSY), .OVERRUN(OVERRUN)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Check the presented word, then let one edge transfer it.
    task automatic get_word(input string tag, input logic [15:0] exp);
        int n = 0;
        while (TX_VALID !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_valid"}, 32'(TX_VALID), 32'd1);
        chk(tag, 32'(TX_DATA), 32'(exp));
        tick();
    endtask

    task automatic count_done(input logic [31:0] v);
        COUNT_VALUE = v;
        COUNT_DONE  = 1'b1;
        tick();
        COUNT_DONE  = 1'b0;
    endtask

    task automatic frame(input string tag, input logic [15:0] hdr, input logic [15:0] hi,
                         input logic [15:0] lo, input logic [15:0] cs,
                         input logic with_done, input logic [31:0] dv);
        READ_REQ = 1'b1;
        if (with_done) begin
            COUNT_VALUE = dv;
            COUNT_DONE  = 1'b1;
        end
        tick();
        COUNT_DONE = 1'b0;
        chk({tag, "_lat1_valid"}, 32'(TX_VALID), 32'd0);
        chk({tag, "_busy"}, 32'(BUSY), 32'd1);
        chk({tag, "_ovr_clr"}, 32'(OVERRUN), 32'd0);
        tick();
        chk({tag, "_lat2_valid"}, 32'(TX_VALID), 32'd1);
        get_word({tag, "_hdr"}, hdr);
        get_word({tag, "_hi"}, hi);
        get_word({tag, "_lo"}, lo);
`ifdef FRAME_CHECKSUM_EN
        get_word({tag, "_cs"}, cs);
`endif
        chk({tag, "_end_valid"}, 32'(TX_VALID), 32'd0);
        chk({tag, "_end_busy"}, 32'(BUSY), 32'd0);
        READ_REQ = 1'b0;
        tick();
    endtask

    initial begin
        logic [15:0] h;
        #1;
        chk("rst_data", 32'(TX_DATA), 32'd0);
        chk("rst_valid", 32'(TX_VALID), 32'd0);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_ovr", 32'(OVERRUN), 32'd0);
        tick();
        RST = 1'b0;
        tick();

        count_done(32'h0001_2345);
        frame("f1", 16'hA580, 16'h0001, 16'h2345, 16'hC8C6, 1'b0, 32'd0);
        frame("f2", 16'hA501, 16'h0001, 16'h2345, 16'hC847, 1'b0, 32'd0);

        // Stall at CNT_HI with an overrunning count arriving mid-frame.
        READ_REQ = 1'b1;
        tick();
        tick();
        get_word("st_hdr", 16'hA502);
        TX_READY = 1'b0;
        COUNT_VALUE = 32'hFFFF_FFFF;
        COUNT_DONE  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            COUNT_DONE = 1'b0;
            chk("st_hold_valid", 32'(TX_VALID), 32'd1);
            chk("st_hold_data", 32'(TX_DATA), 32'h0001);
        end
        chk("st_ovr_set", 32'(OVERRUN), 32'd1);
        TX_READY = 1'b1;
        get_word("st_hi", 16'h0001);
        get_word("st_lo", 16'h2345);
`ifdef FRAME_CHECKSUM_EN
        get_word("st_cs", 16'hC848);
`endif
        chk("st_end_valid", 32'(TX_VALID), 32'd0);
        chk("st_ovr_sticky", 32'(OVERRUN), 32'd1);
        READ_REQ = 1'b0;
        tick();

        frame("f4", 16'hA583, 16'hFFFF, 16'hFFFF, 16'hA581, 1'b0, 32'd0);
        frame("f5", 16'hA584, 16'h0BEE, 16'hF00D, 16'hA17F, 1'b1, 32'h0BEE_F00D);

        for (int s = 5; s < 64; s++) begin
            h = 16'hA500 + 16'(s);
            frame("wrap", h, 16'h0BEE, 16'hF00D, h + 16'h0BEE + 16'hF00D, 1'b0, 32'd0);
        end
        frame("seq0", 16'hA500, 16'h0BEE, 16'hF00D, 16'hA0FB, 1'b0, 32'd0);

        // Reset while CNT_LO is being presented.
        READ_REQ = 1'b1;
        tick();
        tick();
        get_word("rs_hdr", 16'hA501);
        get_word("rs_hi", 16'h0BEE);
        chk("rs_lo_shown", 32'(TX_DATA), 32'hF00D);
        #2;
        RST = 1'b1;
        READ_REQ = 1'b0;
        #1;
        chk("rs_data", 32'(TX_DATA), 32'd0);
        chk("rs_valid", 32'(TX_VALID), 32'd0);
        chk("rs_busy", 32'(BUSY), 32'd0);
        chk("rs_ovr", 32'(OVERRUN), 32'd0);
        tick();
        RST = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("rs_idle_valid", 32'(TX_VALID), 32'd0);
        end
        frame("post", 16'hA500, 16'h0000, 16'h0000, 16'hA500, 1'b0, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
